// File: rtl/onehot_pkg.sv
// Shared types and constants for the one-hot ring monitor.
// State encoding and error-code values used by the top and the bench.
package onehot_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PATTERN = 2'b01;
    localparam logic [1:0] ERR_JUMP    = 2'b10;

endpackage

// File: rtl/onehot_dec.sv
// One-hot to binary decoder with a legality flag.
// legal_o is high only when exactly one input bit is set.
module onehot_dec #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             legal_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;

    // OR together the positions of set bits while counting them
    always_comb begin
        idx_o = '0;
        cnt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
                cnt   = cnt + CNT_W'(1);
            end
        end
        legal_o = (cnt == CNT_W'(1));
    end

endmodule

// File: rtl/onehot_ring_mon.sv
// Monitor for a one-hot ring counter bus: decode, track, flag errors.
// Optional wrap counter enabled by ONEHOT_RING_MON_WRAP_CNT_EN.
module onehot_ring_mon
    import onehot_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int WRAP_W = 8,
    localparam int IDX_W  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  y_in,
    input  logic              clr_err,
    output logic [IDX_W-1:0]  idx_out,
    output logic              idx_valid,
    output logic              step,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] samp_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic [IDX_W-1:0] dec_idx;
    logic             dec_legal;
    logic [IDX_W-1:0] nxt_idx;

    onehot_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .vec_i   (samp_q),
        .idx_o   (dec_idx),
        .legal_o (dec_legal)
    );

    // Index that a legal single advance would produce
    assign nxt_idx = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);

    // Input sample register: first pipeline stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q <= '0;
        end else begin
            samp_q <= y_in;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
            idx_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Next-state and output decode from the sampled vector
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        unique case (state_q)
            SYNC: begin
                // Garbage before lock-on is tolerated silently
                if (dec_legal) begin
                    state_d = TRACK;
                    idx_d   = dec_idx;
                    valid_d = 1'b1;
                end
            end
            TRACK: begin
                if (!dec_legal) begin
                    state_d = ERR;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    code_d  = ERR_PATTERN;
                end else if (dec_idx == idx_q) begin
                    idx_d = idx_q;
                end else if (dec_idx == nxt_idx) begin
                    idx_d  = dec_idx;
                    step_d = 1'b1;
                end else if (dec_idx == '0) begin
                    // Upstream counter was reset
                    idx_d = '0;
                end else begin
                    state_d = ERR;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    code_d  = ERR_JUMP;
                end
            end
            ERR: begin
                // First error is kept until explicitly cleared
                if (clr_err) begin
                    state_d = SYNC;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                end
            end
            default: begin
                state_d = SYNC;
                valid_d = 1'b0;
            end
        endcase
    end

`ifdef ONEHOT_RING_MON_WRAP_CNT_EN
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              wrap_ev;
    logic              wrap_clr;

    assign wrap_ev  = (state_q == TRACK) && dec_legal &&
                      (idx_q == LAST) && (dec_idx == '0);
    assign wrap_clr = (state_q == ERR) && clr_err;

    // Saturating count of completed rings
    always_comb begin
        wrap_d = wrap_q;
        if (wrap_clr) begin
            wrap_d = '0;
        end else if (wrap_ev && (wrap_q != '1)) begin
            wrap_d = wrap_q + WRAP_W'(1);
        end
    end

    // Wrap counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap_cnt = wrap_q;
`else
    assign wrap_cnt = '0;
`endif

    assign idx_out   = idx_q;
    assign idx_valid = valid_q;
    assign step      = step_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule
